// File: rtl/tri_bus_arbiter_if.sv
// Request/grant bundle between the agents and the shared-bus arbiter.
// The tristate net itself stays outside so it can be declared tri or tri1 by the integrator.
interface tri_bus_arbiter_if #(
  parameter int N_AGENTS = 4,
  parameter int WIDTH    = 8
);
  logic [N_AGENTS-1:0]         req;
  logic [N_AGENTS*WIDTH-1:0]   agent_data;
  logic [N_AGENTS-1:0]         oe;
  logic [$clog2(N_AGENTS)-1:0] owner;
  logic                        busy;
  logic [WIDTH-1:0]            bus_q;

  modport master (input req, agent_data, output oe, owner, busy, bus_q);
  modport slave  (output req, agent_data, input oe, owner, busy, bus_q);
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner selection for one shared tristate bus, with enforced turnaround
// gaps between owners and a per-owner hold limit.
module tri_bus_arbiter #(
  parameter int N_AGENTS   = 4,
  parameter int WIDTH      = 8,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  tri_bus_arbiter_if.master ifc,
  inout  tri [WIDTH-1:0]    bus
);
  localparam int IW = $clog2(N_AGENTS);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURNAROUND + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t              state_q, state_d;
  logic [N_AGENTS-1:0] oe_q, oe_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [TW-1:0]       turn_q, turn_d;
  logic [WIDTH-1:0]    bus_q_r;

  logic                any_req;
  logic [IW-1:0]       sel;
  logic                grant_now;

  // Rotating priority: scan downward so the smallest offset from rr_q is the last write.
  always_comb begin
    int j;
    j       = 0;
    any_req = 1'b0;
    sel     = '0;
    for (int i = N_AGENTS - 1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      if (j >= N_AGENTS) j = j - N_AGENTS;
      if (ifc.req[j]) begin
        any_req = 1'b1;
        sel     = IW'(j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    oe_d      = oe_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    grant_now = 1'b0;
    case (state_q)
      IDLE: grant_now = any_req;
      GRANT: begin
        hold_d = hold_q + HW'(1);
        if (!ifc.req[owner_q] || hold_q == HW'(MAX_HOLD - 1)) begin
          state_d = TURN;
          oe_d    = '0;
          turn_d  = '0;
        end
      end
      TURN: begin
        turn_d = turn_q + TW'(1);
        if (turn_q == TW'(TURNAROUND - 1)) begin
          if (any_req) grant_now = 1'b1;
          else         state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_now) begin
      state_d   = GRANT;
      oe_d      = '0;
      oe_d[sel] = 1'b1;
      owner_d   = sel;
      hold_d    = '0;
      rr_d      = (sel == IW'(N_AGENTS - 1)) ? '0 : sel + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      oe_q    <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      bus_q_r <= '0;
    end else begin
      state_q <= state_d;
      oe_q    <= oe_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      bus_q_r <= bus;
    end
  end

  // Drive follows the registered enable, so reset floats the bus without a clock.
  assign bus = (|oe_q) ? ifc.agent_data[int'(owner_q)*WIDTH +: WIDTH] : {WIDTH{1'bz}};

  assign ifc.oe    = oe_q;
  assign ifc.owner = owner_q;
  assign ifc.busy  = |oe_q;
  assign ifc.bus_q = bus_q_r;
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scoreboard bench: a cycle-level ownership model predicts each cycle's outputs,
// a monitor compares them on the falling edge and also tracks the gap invariants.
module tb_tri_bus_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TA = 1;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tri1 [W-1:0] bus;
  tri_bus_arbiter_if #(.N_AGENTS(N), .WIDTH(W)) ifc ();

  tri_bus_arbiter #(.N_AGENTS(N), .WIDTH(W), .TURNAROUND(TA), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .ifc(ifc), .bus(bus));

  typedef struct {
    logic [N-1:0] oe;
    int           owner;
    logic         busy;
    logic [W-1:0] bus;
    logic [W-1:0] bus_q;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Ownership model: phase 0 = nobody, 1 = owned, 2 = enforced gap.
  int m_phase = 0, m_owner = 0, m_held = 0, m_gap = 0, m_ptr = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int pick(logic [N-1:0] r, int ptr);
    for (int i = 0; i < N; i++)
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] data_of(int a);
    return ifc.agent_data[a*W +: W];
  endfunction

  task automatic grant_to(int s);
    m_phase = 1;
    m_owner = s;
    m_held  = 0;
    m_ptr   = (s + 1) % N;
  endtask

  initial begin
    exp_t e;
    logic [N-1:0] r;
    int s;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_owner = 0; m_held = 0; m_gap = 0; m_ptr = 0;
        q.delete();
      end else begin
        r = ifc.req;
        e.bus_q = (m_phase == 1) ? data_of(m_owner) : '1;
        case (m_phase)
          0: begin
            s = pick(r, m_ptr);
            if (s >= 0) grant_to(s);
          end
          1: begin
            m_held++;
            if (!r[m_owner] || m_held == MH) begin
              m_phase = 2;
              m_gap   = 0;
            end
          end
          default: begin
            m_gap++;
            if (m_gap == TA) begin
              s = pick(r, m_ptr);
              if (s >= 0) grant_to(s);
              else        m_phase = 0;
            end
          end
        endcase
        e.busy  = (m_phase == 1);
        e.oe    = e.busy ? (N'(1) << m_owner) : '0;
        e.owner = m_owner;
        e.bus   = e.busy ? data_of(m_owner) : '1;
        q.push_back(e);
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    logic [N-1:0] prev_oe;
    int zero_run;
    bit had_owner;
    prev_oe = '0; zero_run = 0; had_owner = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_oe = '0; zero_run = 0; had_owner = 0;
      end else if (q.size() == 0) begin
        check("scoreboard_underflow", 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        check("oe", 32'(ifc.oe), 32'(e.oe));
        check("busy", 32'(ifc.busy), 32'(e.busy));
        check("bus", 32'(bus), 32'(e.bus));
        check("bus_q", 32'(ifc.bus_q), 32'(e.bus_q));
        if (e.busy) check("owner", 32'(ifc.owner), 32'(e.owner));
        check("oe_onehot0", 32'($onehot0(ifc.oe)), 32'd1);
        if (ifc.oe == '0) zero_run++;
        else begin
          if (prev_oe != '0) check("oe_no_direct_switch", 32'(ifc.oe), 32'(prev_oe));
          else if (had_owner) check("turnaround_gap", 32'(zero_run >= TA), 32'd1);
          zero_run  = 0;
          had_owner = 1;
        end
        prev_oe = ifc.oe;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Returns right at the falling edge where agent a's enable is seen.
  task automatic wait_grant(int a, int max_cycles);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (ifc.oe[a]) begin
        ok = 1;
        break;
      end
    end
    check("grant_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.req = '0;
    ifc.agent_data = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_oe", 32'(ifc.oe), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_owner", 32'(ifc.owner), 32'd0);
    check("rst_bus_q", 32'(ifc.bus_q), 32'd0);
    check("rst_bus", 32'(bus), 32'hFF);
    rst_n = 1'b1;

    // Single request, one-cycle grant latency
    ifc.agent_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    ifc.req = 4'b0100;
    wait_grant(2, 1);
    check("single_oe", 32'(ifc.oe), 32'h4);
    check("single_owner", 32'(ifc.owner), 32'd2);
    check("single_bus", 32'(bus), 32'hA5);
    #1;
    tick();
    check("single_bus_q", 32'(ifc.bus_q), 32'hA5);
    ifc.req = '0;
    repeat (4) tick();

    // Full contention with hold limit
    ifc.req = 4'b1111;
    repeat (45) tick();
    ifc.req = '0;
    repeat (12) tick();

    // Early release after three owned cycles
    ifc.req = 4'b0010;
    wait_grant(1, 4);
    #1;
    tick();
    tick();
    ifc.req = '0;
    repeat (4) tick();
    check("early_busy", 32'(ifc.busy), 32'd0);
    check("early_oe", 32'(ifc.oe), 32'd0);
    check("early_bus_q", 32'(ifc.bus_q), 32'hFF);

    // Pointer wrap: after agent2, agent0 beats agent1
    ifc.req = 4'b0100;
    wait_grant(2, 4);
    #1;
    ifc.req = '0;
    repeat (3) tick();
    ifc.req = 4'b0011;
    wait_grant(0, 4);
    check("wrap_owner", 32'(ifc.owner), 32'd0);
    #1;
    ifc.req = '0;
    repeat (3) tick();

    // Asynchronous reset while agent3 drives
    ifc.agent_data[3*W +: W] = 8'h3C;
    ifc.req = 4'b1000;
    wait_grant(3, 4);
    #1;
    tick();
    check("pre_rst_bus", 32'(bus), 32'h3C);
    rst_n = 1'b0;
    #1;
    check("async_rst_oe", 32'(ifc.oe), 32'd0);
    check("async_rst_busy", 32'(ifc.busy), 32'd0);
    check("async_rst_bus", 32'(bus), 32'hFF);
    tick();
    tick();
    rst_n = 1'b1;
    wait_grant(3, 1);
    check("regrant_bus", 32'(bus), 32'h3C);
    #1;
    ifc.req = '0;
    repeat (3) tick();

    // Random traffic with one reset pulse in the middle
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) ifc.req = N'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) ifc.agent_data = $urandom;
      if (i == 1000) rst_n = 1'b0;
      if (i == 1002) rst_n = 1'b1;
      tick();
    end
    ifc.req = '0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
